// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, FSM state type and writeback request payload for the
// writeback arbiter slice.
package wb_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 16;
  localparam int unsigned AW    = $clog2(NREGS);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [AW-1:0]   rdadr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-load vector and decode hazard detection.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   issue_valid/_rdadr  load issued to memory, marks destination pending
//   clr_valid/_rdadr    load commit being registered this edge, clears pending
//   rs1adr, rs2adr      decode source addresses
//   alu_valid/_rdadr    ALU writeback destination (checked when valid)
//   regwrite, rdadr     registered write port currently in flight
//   hazard              combinational stall request
module wb_scoreboard #(
  parameter int unsigned NREGS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic [$clog2(NREGS)-1:0] issue_rdadr,
  input  logic                     clr_valid,
  input  logic [$clog2(NREGS)-1:0] clr_rdadr,
  input  logic [$clog2(NREGS)-1:0] rs1adr,
  input  logic [$clog2(NREGS)-1:0] rs2adr,
  input  logic                     alu_valid,
  input  logic [$clog2(NREGS)-1:0] alu_rdadr,
  input  logic                     regwrite,
  input  logic [$clog2(NREGS)-1:0] rdadr,
  output logic                     hazard
);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;
  logic             w_hit_rs1;
  logic             w_hit_rs2;
  logic             w_hit_alu;

  // Set/clear masks; x0 is never marked pending.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue_valid && (issue_rdadr != '0)) w_set[issue_rdadr] = 1'b1;
    if (clr_valid)                          w_clr[clr_rdadr]   = 1'b1;
  end

  // Set is OR-ed in after the clear so a same-edge re-issue keeps the bit.
  always_ff @(posedge clk) begin
    if (!reset) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_clr) | w_set;
  end

  assign w_hit_rs1 = (rs1adr != '0) &&
                     (r_pending[rs1adr] || (regwrite && (rs1adr == rdadr)));
  assign w_hit_rs2 = (rs2adr != '0) &&
                     (r_pending[rs2adr] || (regwrite && (rs2adr == rdadr)));
  assign w_hit_alu = alu_valid && (alu_rdadr != '0) &&
                     (r_pending[alu_rdadr] || (regwrite && (alu_rdadr == rdadr)));

  assign hazard = w_hit_rs1 | w_hit_rs2 | w_hit_alu;

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and load writebacks onto one registered register-file
// write port. ALU has priority; a colliding load is parked in a one-entry hold
// buffer and committed on the next ALU-free cycle.
// Macro WB_SCOREBOARD_EN: when defined, instantiates wb_scoreboard (pending
// vector + full hazard); otherwise hazard covers only the write in flight.
// Ports:
//   clk, reset                         clock, synchronous active-low reset
//   alu_valid/_rdadr/_data             ALU writeback (no backpressure)
//   ld_valid/_ready/_rdadr/_data       load response handshake
//   issue_valid/_rdadr                 load issued to memory
//   rs1adr, rs2adr                     decode source addresses
//   hazard                             combinational stall request
//   regwrite, rdadr, rd                registered register-file write port
module wb_arbiter #(
  parameter int unsigned XLEN  = wb_pkg::XLEN,
  parameter int unsigned NREGS = wb_pkg::NREGS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [$clog2(NREGS)-1:0] alu_rdadr,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [$clog2(NREGS)-1:0] ld_rdadr,
  input  logic [XLEN-1:0]          ld_data,
  input  logic                     issue_valid,
  input  logic [$clog2(NREGS)-1:0] issue_rdadr,
  input  logic [$clog2(NREGS)-1:0] rs1adr,
  input  logic [$clog2(NREGS)-1:0] rs2adr,
  output logic                     hazard,
  output logic                     regwrite,
  output logic [$clog2(NREGS)-1:0] rdadr,
  output logic [XLEN-1:0]          rd
);
  import wb_pkg::*;

  localparam int unsigned ADR_W = $clog2(NREGS);

  wb_state_e         r_state;
  wb_state_e         w_state_nxt;
  wb_req_t           r_hold;
  wb_req_t           w_sel;
  wb_req_t           w_alu_req;
  wb_req_t           w_ld_req;
  logic              w_ld_hs;
  logic              w_commit;
  logic              w_commit_ld;
  logic              w_capture;
  logic              r_regwrite;
  logic [ADR_W-1:0]  r_rdadr;
  logic [XLEN-1:0]   r_rd;

  assign w_alu_req = '{rdadr: alu_rdadr, data: alu_data};
  assign w_ld_req  = '{rdadr: ld_rdadr,  data: ld_data};
  assign ld_ready  = (r_state == IDLE);
  assign w_ld_hs   = ld_valid & ld_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (alu_valid && w_ld_hs) w_state_nxt = HOLD;
      HOLD:    if (!alu_valid)           w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Commit selection: ALU always wins; the buffered load drains when ALU idles.
  always_comb begin
    w_commit    = 1'b0;
    w_commit_ld = 1'b0;
    w_capture   = 1'b0;
    w_sel       = w_alu_req;
    case (r_state)
      IDLE: begin
        if (alu_valid) begin
          w_commit  = 1'b1;
          w_capture = w_ld_hs;
        end else if (w_ld_hs) begin
          w_commit    = 1'b1;
          w_commit_ld = 1'b1;
          w_sel       = w_ld_req;
        end
      end
      HOLD: begin
        w_commit = 1'b1;
        if (!alu_valid) begin
          w_commit_ld = 1'b1;
          w_sel       = r_hold;
        end
      end
      default: ;
    endcase
  end

  // Hold buffer
  always_ff @(posedge clk) begin
    if (!reset)         r_hold <= '0;
    else if (w_capture) r_hold <= w_ld_req;
  end

  // Registered write port; a commit to x0 is swallowed but still advances.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_regwrite <= 1'b0;
      r_rdadr    <= '0;
      r_rd       <= '0;
    end else if (w_commit) begin
      r_regwrite <= (w_sel.rdadr != '0);
      r_rdadr    <= w_sel.rdadr;
      r_rd       <= w_sel.data;
    end else begin
      r_regwrite <= 1'b0;
    end
  end

  assign regwrite = r_regwrite;
  assign rdadr    = r_rdadr;
  assign rd       = r_rd;

`ifdef WB_SCOREBOARD_EN
  wb_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rdadr (issue_rdadr),
    .clr_valid   (w_commit_ld),
    .clr_rdadr   (w_sel.rdadr),
    .rs1adr      (rs1adr),
    .rs2adr      (rs2adr),
    .alu_valid   (alu_valid),
    .alu_rdadr   (alu_rdadr),
    .regwrite    (r_regwrite),
    .rdadr       (r_rdadr),
    .hazard      (hazard)
  );
`else
  // Without pending tracking only the write in flight can collide.
  logic w_unused_issue;
  assign w_unused_issue = ^{issue_valid, issue_rdadr, w_commit_ld};
  assign hazard = r_regwrite && (r_rdadr != '0) &&
                  ((r_rdadr == rs1adr) || (r_rdadr == rs2adr));
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios followed by random traffic, compared against
// a queue-based reference model of the writeback arbiter.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [3:0]  alu_rdadr;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_rdadr;
  logic [31:0] ld_data;
  logic        issue_valid;
  logic [3:0]  issue_rdadr;
  logic [3:0]  rs1adr;
  logic [3:0]  rs2adr;
  logic        hazard;
  logic        regwrite;
  logic [3:0]  rdadr;
  logic [31:0] rd;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rdadr   (alu_rdadr),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rdadr    (ld_rdadr),
    .ld_data     (ld_data),
    .issue_valid (issue_valid),
    .issue_rdadr (issue_rdadr),
    .rs1adr      (rs1adr),
    .rs2adr      (rs2adr),
    .hazard      (hazard),
    .regwrite    (regwrite),
    .rdadr       (rdadr),
    .rd          (rd)
  );

  // Reference model state
  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } wb_t;

  wb_t         hold_q[$];
  bit          pend[16];
  logic        m_regwrite;
  logic [3:0]  m_rdadr;
  logic [31:0] m_rd;
  bit          m_port_known;
  bit          m_known;

  int n_total;
  int n_pass;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input logic [3:0] a);
    return (a != 4'd0) && (pend[a] || (m_regwrite && (a == m_rdadr)));
  endfunction

  function automatic bit exp_hazard();
`ifdef WB_SCOREBOARD_EN
    return hit(rs1adr) || hit(rs2adr) || (alu_valid && hit(alu_rdadr));
`else
    return m_regwrite && (m_rdadr != 4'd0) &&
           ((m_rdadr == rs1adr) || (m_rdadr == rs2adr));
`endif
  endfunction

  task automatic commit(input logic [3:0] a, input logic [31:0] d);
    m_regwrite = (a != 4'd0);
    m_rdadr    = a;
    m_rd       = d;
    m_port_known = (a != 4'd0);
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_edge();
    bit   hs;
    bit   clr;
    logic [3:0] clr_a;
    wb_t  e;
    if (!reset) begin
      m_regwrite = 1'b0;
      m_rdadr    = 4'd0;
      m_rd       = 32'd0;
      m_port_known = 1'b1;
      m_known    = 1'b1;
      foreach (pend[i]) pend[i] = 1'b0;
      hold_q.delete();
      return;
    end
    hs  = ld_valid && (hold_q.size() == 0);
    clr = 1'b0;
    clr_a = 4'd0;
    if (alu_valid) begin
      commit(alu_rdadr, alu_data);
      if (hs) hold_q.push_back('{a: ld_rdadr, d: ld_data});
    end else if (hold_q.size() != 0) begin
      e = hold_q.pop_front();
      commit(e.a, e.d);
      clr = 1'b1; clr_a = e.a;
    end else if (hs) begin
      commit(ld_rdadr, ld_data);
      clr = 1'b1; clr_a = ld_rdadr;
    end else begin
      m_regwrite = 1'b0;
    end
    if (clr) pend[clr_a] = 1'b0;
    if (issue_valid && (issue_rdadr != 4'd0)) pend[issue_rdadr] = 1'b1;
  endtask

  // One cycle: inputs already driven just after the previous edge.
  task automatic cycle();
    #2;
    if (m_known) begin
      check("ld_ready", {31'd0, ld_ready}, {31'd0, hold_q.size() == 0});
      check("hazard",   {31'd0, hazard},   {31'd0, exp_hazard()});
    end
    model_edge();
    @(posedge clk);
    #1;
    check("regwrite", {31'd0, regwrite}, {31'd0, m_regwrite});
    if (m_port_known) begin
      check("rdadr", {28'd0, rdadr}, {28'd0, m_rdadr});
      check("rd",    rd,             m_rd);
    end
  endtask

  task automatic quiet();
    reset = 1'b1;
    alu_valid = 1'b0; alu_rdadr = 4'd0; alu_data = 32'd0;
    ld_valid = 1'b0;  ld_rdadr = 4'd0;  ld_data = 32'd0;
    issue_valid = 1'b0; issue_rdadr = 4'd0;
    rs1adr = 4'd0; rs2adr = 4'd0;
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0;
    m_known = 1'b0; m_port_known = 1'b0;
    m_regwrite = 1'b0; m_rdadr = 4'd0; m_rd = 32'd0;
    quiet();
    @(posedge clk); #1;

    // Reset
    reset = 1'b0;
    cycle();
    cycle();
    check("reset_ld_ready", {31'd0, ld_ready}, 32'd1);
    reset = 1'b1;

    // Single ALU write
    alu_valid = 1'b1; alu_rdadr = 4'd5; alu_data = 32'hDEADBEEF;
    cycle();
    check("alu_rd_literal", rd, 32'hDEADBEEF);
    quiet(); cycle();

    // ALU and load collide: ALU first, load one cycle later
    alu_valid = 1'b1; alu_rdadr = 4'd3; alu_data = 32'h11;
    ld_valid  = 1'b1; ld_rdadr  = 4'd7; ld_data  = 32'h22;
    cycle();
    check("collide_ready_low", {31'd0, ld_ready}, 32'd0);
    quiet();
    cycle();
    check("collide_load_rd", rd, 32'h22);
    check("collide_ready_high", {31'd0, ld_ready}, 32'd1);
    cycle();

    // Pending load to x9 read by decode
    issue_valid = 1'b1; issue_rdadr = 4'd9;
    cycle();
    quiet(); rs1adr = 4'd9;
    cycle(); cycle();
    // Load commits to x9 while x9 is re-issued on the same edge
    ld_valid = 1'b1; ld_rdadr = 4'd9; ld_data = 32'h99;
    issue_valid = 1'b1; issue_rdadr = 4'd9;
    cycle();
    quiet(); rs1adr = 4'd9;
    cycle();
    ld_valid = 1'b1; ld_rdadr = 4'd9; ld_data = 32'h98;
    cycle();
    quiet(); rs1adr = 4'd9;
    cycle(); cycle();

    // Writes and issues to x0
    alu_valid = 1'b1; alu_rdadr = 4'd0; alu_data = 32'h55;
    issue_valid = 1'b1; issue_rdadr = 4'd0;
    cycle();
    check("x0_no_write", {31'd0, regwrite}, 32'd0);
    quiet(); rs1adr = 4'd0; rs2adr = 4'd0;
    cycle();

    // Reset while holding a load discards it
    issue_valid = 1'b1; issue_rdadr = 4'd12;
    cycle();
    quiet();
    alu_valid = 1'b1; alu_rdadr = 4'd2; alu_data = 32'hA5;
    ld_valid  = 1'b1; ld_rdadr  = 4'd12; ld_data = 32'hBAD;
    cycle();
    quiet(); reset = 1'b0;
    cycle();
    quiet(); rs1adr = 4'd12;
    cycle();
    check("post_reset_no_held", {31'd0, regwrite}, 32'd0);
    cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 49) != 0);
      alu_valid   = ($urandom_range(0, 1) == 1);
      alu_rdadr   = 4'($urandom_range(0, 15));
      alu_data    = $urandom;
      ld_valid    = ($urandom_range(0, 9) < 4);
      ld_rdadr    = 4'($urandom_range(0, 15));
      ld_data     = $urandom;
      issue_valid = ($urandom_range(0, 9) < 3);
      issue_rdadr = 4'($urandom_range(0, 15));
      rs1adr      = 4'($urandom_range(0, 15));
      rs2adr      = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
